// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between two ports
// Optional illegal-op check (ctrl 14/15) enabled by defining ALU_ARB_ILLEGAL_CHK_EN.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [DATA_W-1:0] req0_data1,
  input  logic [DATA_W-1:0] req0_data2,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic [DATA_W-1:0] req1_data1,
  input  logic [DATA_W-1:0] req1_data2,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [DATA_W-1:0] resp0_data,
  output logic              resp0_err,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp1_data,
  output logic              resp1_err,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [DATA_W-1:0] alu_data1,
  output logic [DATA_W-1:0] alu_data2,
  input  logic [DATA_W-1:0] alu_out,
  output logic              busy
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t            state, state_nxt;
  logic              rr_ptr;
  logic              owner;
  logic              op_ill;
  logic              elig0, elig1;
  logic              grant0, grant1;
  logic [CTRL_W-1:0] sel_ctrl;
  logic [DATA_W-1:0] sel_d1, sel_d2;
  logic              sel_ill;

  // A port may only win if its single result slot is free or being retired now.
  always_comb begin
    elig0      = req0_valid && (!resp0_valid || resp0_ready);
    elig1      = req1_valid && (!resp1_valid || resp1_ready);
    grant0     = elig0 && (!elig1 || !rr_ptr);
    grant1     = elig1 && (!elig0 || rr_ptr);
    req0_ready = (state == IDLE) && grant0;
    req1_ready = (state == IDLE) && grant1;
    sel_ctrl   = grant1 ? req1_ctrl  : req0_ctrl;
    sel_d1     = grant1 ? req1_data1 : req0_data1;
    sel_d2     = grant1 ? req1_data2 : req0_data2;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
    sel_ill    = (sel_ctrl >= CTRL_W'(14));
`else
    sel_ill    = 1'b0;
`endif
    state_nxt  = state;
    case (state)
      IDLE:    if (grant0 || grant1) state_nxt = EXEC;
      EXEC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == EXEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= 1'b0;
      owner       <= 1'b0;
      op_ill      <= 1'b0;
      alu_ctrl    <= '0;
      alu_data1   <= '0;
      alu_data2   <= '0;
      resp0_valid <= 1'b0;
      resp0_data  <= '0;
      resp0_err   <= 1'b0;
      resp1_valid <= 1'b0;
      resp1_data  <= '0;
      resp1_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      // Operand registers double as the ALU drive, so alu_* only move on a grant.
      if (state == IDLE && (grant0 || grant1)) begin
        owner     <= grant1;
        op_ill    <= sel_ill;
        alu_ctrl  <= sel_ill ? '0 : sel_ctrl;
        alu_data1 <= sel_d1;
        alu_data2 <= sel_d2;
      end
      if (state == EXEC) rr_ptr <= ~owner;

      if (state == EXEC && !owner) begin
        resp0_valid <= 1'b1;
        resp0_data  <= op_ill ? '0 : alu_out;
        resp0_err   <= op_ill;
      end else if (resp0_valid && resp0_ready) begin
        resp0_valid <= 1'b0;
        resp0_err   <= 1'b0;
      end

      if (state == EXEC && owner) begin
        resp1_valid <= 1'b1;
        resp1_data  <= op_ill ? '0 : alu_out;
        resp1_err   <= op_ill;
      end else if (resp1_valid && resp1_ready) begin
        resp1_valid <= 1'b0;
        resp1_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic [31:0] req0_data1, req0_data2, req1_data1, req1_data2;
  logic        resp0_valid, resp0_ready, resp0_err;
  logic        resp1_valid, resp1_ready, resp1_err;
  logic [31:0] resp0_data, resp1_data;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_data1, alu_data2, alu_out;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int accepts;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(32), .CTRL_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
    .req0_data1(req0_data1), .req0_data2(req0_data2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
    .req1_data1(req1_data1), .req1_data2(req1_data2),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data), .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data), .resp1_err(resp1_err),
    .alu_ctrl(alu_ctrl), .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_out(alu_out),
    .busy(busy)
  );

  // Reference ALU: codes 0-13 defined, anything else returns 0.
  always_comb begin
    alu_out = 32'h0;
    case (alu_ctrl)
      4'd0:  alu_out = alu_data1 & alu_data2;
      4'd1:  alu_out = alu_data1 | alu_data2;
      4'd2:  alu_out = alu_data1 + alu_data2;
      4'd3:  alu_out = alu_data1 - alu_data2;
      4'd4:  alu_out = alu_data1 ^ alu_data2;
      4'd5:  alu_out = ~(alu_data1 | alu_data2);
      4'd6:  alu_out = {31'h0, alu_data1 < alu_data2};
      4'd7:  alu_out = {31'h0, $signed(alu_data1) < $signed(alu_data2)};
      4'd8:  alu_out = alu_data1;
      4'd9:  alu_out = alu_data2;
      4'd10: alu_out = ~(alu_data1 & alu_data2);
      4'd11: alu_out = alu_data1 << alu_data2[4:0];
      4'd12: alu_out = alu_data1 >> alu_data2[4:0];
      4'd13: alu_out = $unsigned($signed(alu_data1) >>> alu_data2[4:0]);
      default: alu_out = 32'h0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req0_ctrl = 0; req0_data1 = 0; req0_data2 = 0;
    req1_valid = 0; req1_ctrl = 0; req1_data1 = 0; req1_data2 = 0;
    resp0_ready = 0; resp1_ready = 0;

    #2;
    chk("rst_busy", busy, 0);
    chk("rst_resp0_valid", resp0_valid, 0);
    chk("rst_resp1_valid", resp1_valid, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    chk("rst_resp0_data", resp0_data, 0);
    @(negedge clk); rst_n = 1'b1;

    // Port 0 alone: 5 + 7
    @(negedge clk);
    req0_valid = 1; req0_ctrl = 4'd2; req0_data1 = 5; req0_data2 = 7;
    #1;
    chk("t1_req0_ready", req0_ready, 1);
    chk("t1_req1_ready", req1_ready, 0);
    @(negedge clk); req0_valid = 0; #1;
    chk("t1_busy", busy, 1);
    chk("t1_alu_ctrl", alu_ctrl, 2);
    chk("t1_alu_data1", alu_data1, 5);
    chk("t1_req0_ready_exec", req0_ready, 0);
    chk("t1_resp0_valid_early", resp0_valid, 0);
    @(negedge clk); #1;
    chk("t1_resp0_valid", resp0_valid, 1);
    chk("t1_resp0_data", resp0_data, 12);
    chk("t1_resp1_valid", resp1_valid, 0);
    chk("t1_busy_idle", busy, 0);
    chk("t1_alu_hold", alu_ctrl, 2);
    resp0_ready = 1;
    @(negedge clk); #1;
    chk("t1_resp0_retired", resp0_valid, 0);
    resp0_ready = 0;

    // Both ports contending after reset: grants alternate 0,1,0,1
    rst_n = 0; #1; rst_n = 1;
    @(negedge clk);
    req0_valid = 1; req0_ctrl = 4'd3; req0_data1 = 10;           req0_data2 = 3;
    req1_valid = 1; req1_ctrl = 4'd7; req1_data1 = 32'hFFFFFFFF; req1_data2 = 1;
    resp0_ready = 1; resp1_ready = 1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_grant0_%0d", i), req0_ready, (i % 2 == 0));
      chk($sformatf("t2_grant1_%0d", i), req1_ready, (i % 2 == 1));
      @(negedge clk); @(negedge clk); #1;
      if (i % 2 == 0) begin
        chk($sformatf("t2_resp0_valid_%0d", i), resp0_valid, 1);
        chk($sformatf("t2_resp0_data_%0d", i), resp0_data, 7);
      end else begin
        chk($sformatf("t2_resp1_valid_%0d", i), resp1_valid, 1);
        chk($sformatf("t2_resp1_data_%0d", i), resp1_data, 1);
      end
    end
    req0_valid = 0; req1_valid = 0;
    @(negedge clk); @(negedge clk); #1;

    // Port 0 result stalls on resp0_ready=0; port 1 keeps being served
    resp0_ready = 0;
    req0_valid = 1; req0_ctrl = 4'd4; req0_data1 = 32'hFF; req0_data2 = 32'hAA;
    #1;
    chk("t3_req0_ready", req0_ready, 1);
    @(negedge clk); @(negedge clk); #1;
    chk("t3_resp0_valid", resp0_valid, 1);
    chk("t3_resp0_data", resp0_data, 32'h55);
    req0_ctrl = 4'd2; req0_data1 = 1; req0_data2 = 1;
    req1_valid = 1; req1_ctrl = 4'd2; req1_data1 = 3; req1_data2 = 4;
    #1;
    chk("t3_req0_blocked", req0_ready, 0);
    chk("t3_req1_granted", req1_ready, 1);
    @(negedge clk); @(negedge clk); #1;
    chk("t3_resp1_data", resp1_data, 7);
    chk("t3_resp0_hold_data", resp0_data, 32'h55);
    chk("t3_resp0_hold_valid", resp0_valid, 1);
    req1_valid = 0; #1;
    chk("t3_req0_still_blocked", req0_ready, 0);
    resp0_ready = 1; #1;
    chk("t3_req0_same_cycle", req0_ready, 1);
    @(negedge clk); req0_valid = 0; #1;
    chk("t3_resp0_retire", resp0_valid, 0);
    @(negedge clk); #1;
    chk("t3_resp0_new_valid", resp0_valid, 1);
    chk("t3_resp0_new_data", resp0_data, 2);
    @(negedge clk); #1;

    // Asynchronous reset in the middle of an EXEC cycle
    req0_valid = 1; req0_ctrl = 4'd11; req0_data1 = 1; req0_data2 = 4;
    @(negedge clk); req0_valid = 0; #1;
    chk("t4_busy_before", busy, 1);
    chk("t4_alu_ctrl_before", alu_ctrl, 11);
    rst_n = 0; #1;
    chk("t4_busy_rst", busy, 0);
    chk("t4_alu_ctrl_rst", alu_ctrl, 0);
    chk("t4_alu_data2_rst", alu_data2, 0);
    chk("t4_resp0_data_rst", resp0_data, 0);
    #1; rst_n = 1;
    @(negedge clk); @(negedge clk); #1;
    chk("t4_no_resp", resp0_valid, 0);
    req0_valid = 1; #1;
    chk("t4_req0_ready_again", req0_ready, 1);
    @(negedge clk); req0_valid = 0;
    @(negedge clk); #1;
    chk("t4_resp0_valid", resp0_valid, 1);
    chk("t4_resp0_data", resp0_data, 16);
    @(negedge clk); #1;

    // Undefined op code on port 1
    req1_valid = 1; req1_ctrl = 4'd15; req1_data1 = 9; req1_data2 = 9;
    @(negedge clk); req1_valid = 0; #1;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
    chk("t5_alu_ctrl", alu_ctrl, 0);
`else
    chk("t5_alu_ctrl", alu_ctrl, 15);
`endif
    @(negedge clk); #1;
    chk("t5_resp1_valid", resp1_valid, 1);
    chk("t5_resp1_data", resp1_data, 0);
`ifdef ALU_ARB_ILLEGAL_CHK_EN
    chk("t5_resp1_err", resp1_err, 1);
`else
    chk("t5_resp1_err", resp1_err, 0);
`endif
    @(negedge clk); #1;
    chk("t5_err_cleared", resp1_err, 0);
    chk("t5_valid_cleared", resp1_valid, 0);

    // Back-to-back arithmetic shifts on port 1
    accepts = 0;
    req1_valid = 1; req1_ctrl = 4'd13; req1_data1 = 32'h80000000; req1_data2 = 4;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t6_busy_idle_%0d", i), busy, 0);
      chk($sformatf("t6_ready_%0d", i), req1_ready, 1);
      if (req1_ready) accepts++;
      @(negedge clk); #1;
      chk($sformatf("t6_busy_exec_%0d", i), busy, 1);
      chk($sformatf("t6_ready_exec_%0d", i), req1_ready, 0);
      @(negedge clk); #1;
      chk($sformatf("t6_resp1_valid_%0d", i), resp1_valid, 1);
      chk($sformatf("t6_resp1_data_%0d", i), resp1_data, 32'hF8000000);
    end
    chk("t6_accepts", accepts, 3);
    req1_valid = 0;
    @(negedge clk); @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
